// File: rtl/fib_pkg.sv
// Shared types and defaults for the Fibonacci term generator.
package fib_pkg;

  localparam int FIB_WIDTH = 32;
  localparam int FIB_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } fib_state_e;

endpackage

// File: rtl/fib_seq_gen_if.sv
// Term stream handshake between the generator and its consumer.
interface fib_seq_gen_if
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int CNT_W = FIB_CNT_W
);

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_idx;

  modport master (output out_valid, output out_data, output out_idx, input out_ready);
  modport slave  (input out_valid, input out_data, input out_idx, output out_ready);

endinterface

// File: rtl/fib_adder.sv
// Combinational adder for the Fibonacci recurrence; cout flags a wrap past WIDTH bits.
module fib_adder
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/fib_seq_gen.sv
// Fibonacci term generator: loads two seeds on start and streams n_terms terms
// over a valid/ready handshake. Optional build macro FIB_OVF_STOP_EN ends the
// sequence early (without presenting it) when the next term would overflow.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; seeds and count captured on start
// EMIT    | current term presented on out_data, waiting for a handshake
// DONE    | one-cycle done pulse, then back to IDLE
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int CNT_W = FIB_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic [CNT_W-1:0]     n_terms,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf,
  fib_seq_gen_if.master        out_if
);

  fib_state_e       state;
  fib_state_e       state_nxt;

  // cur_term is on the bus; nxt_term is the following term, computed one step
  // ahead, and nxt_carry remembers whether producing it wrapped.
  logic [WIDTH-1:0] cur_term;
  logic [WIDTH-1:0] nxt_term;
  logic             nxt_carry;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] idx_q;
  logic             ovf_q;

  logic             hs;
  logic             last;
  logic             stop;

  fib_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (cur_term),
    .b    (nxt_term),
    .sum  (sum),
    .cout (cout)
  );

  assign hs   = (state == ST_EMIT) && out_if.out_ready;
  assign last = (remaining == CNT_W'(1));

`ifdef FIB_OVF_STOP_EN
  assign stop = nxt_carry;
`else
  assign stop = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start) state_nxt = (n_terms == '0) ? ST_DONE : ST_EMIT;
      ST_EMIT: if (hs && (last || stop)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Seed capture, term advance, counters and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_term  <= '0;
      nxt_term  <= '0;
      nxt_carry <= 1'b0;
      remaining <= '0;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
    end else if ((state == ST_IDLE) && start) begin
      cur_term  <= a_in;
      nxt_term  <= b_in;
      nxt_carry <= 1'b0;
      remaining <= n_terms;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
    end else if (hs) begin
      remaining <= remaining - CNT_W'(1);
      if (!last) ovf_q <= ovf_q | nxt_carry;
      // An early stop leaves out_idx on the last accepted term.
      if (last || !stop) idx_q <= idx_q + CNT_W'(1);
      if (!last && !stop) begin
        cur_term  <= nxt_term;
        nxt_term  <= sum;
        nxt_carry <= cout;
      end
    end
  end

  // Output decode
  always_comb begin
    out_if.out_valid = (state == ST_EMIT);
    out_if.out_data  = cur_term;
    out_if.out_idx   = idx_q;
    busy             = (state == ST_EMIT);
    done             = (state == ST_DONE);
    ovf              = ovf_q;
  end

endmodule
